// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with a per-register busy
// scoreboard for RAW/WAW interlock in decode.
//   - NRD combinational read ports, two write ports (0 = ALU, 1 = load/late).
//   - Register 0 reads as zero; writes and issues to it are dropped.
//   - Optional same-cycle write-to-read bypass, enabled by defining the
//     macro REGFILE_BYPASS_EN (default build: no bypass).
//
// Interface timing: we0/we1 and iss_valid are single-cycle strobes sampled
// on the rising clock edge. There is no backpressure; an asserted strobe
// always takes effect on that edge unless rst is high.
module reg_file_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs_flat,
  output logic [NRD*XLEN-1:0] rd_flat,
  output logic [NRD-1:0]      rbusy,
  input  logic                we0,
  input  logic [AW-1:0]       wr0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wr1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_waw,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     busy_cnt_q, busy_cnt_d;
  logic [AW:0]     set_n, clr_n;

  // Strobes qualified so that index 0 never takes part.
  logic w0_act, w1_act, iss_act;
  assign w0_act  = we0 && (wr0 != '0);
  assign w1_act  = we1 && (wr1 != '0);
  assign iss_act = iss_valid && (iss_rd != '0);

  // Next register contents: port 1 is applied last so it wins a collision.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
      if (w0_act && (wr0 == AW'(r))) regs_d[r] = wd0;
      if (w1_act && (wr1 == AW'(r))) regs_d[r] = wd1;
    end
    regs_d[0] = '0;
  end

  // Next busy bits: writeback clears, issue sets last so a new producer wins.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_d[r] = busy_q[r];
      if (w0_act && (wr0 == AW'(r))) busy_d[r] = 1'b0;
      if (w1_act && (wr1 == AW'(r))) busy_d[r] = 1'b0;
      if (iss_act && (iss_rd == AW'(r))) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy count tracks popcount incrementally from bits that rise and fall.
  always_comb begin
    set_n = '0;
    clr_n = '0;
    for (int r = 0; r < NREG; r++) begin
      set_n = set_n + (AW+1)'(busy_d[r] & ~busy_q[r]);
      clr_n = clr_n + (AW+1)'(busy_q[r] & ~busy_d[r]);
    end
    busy_cnt_d = busy_cnt_q + set_n - clr_n;
  end

  // State registers; reset wipes data, scoreboard and count immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= regs_d[r];
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;
  assign iss_waw  = iss_act && busy_q[iss_rd];

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign idx = rs_flat[g*AW +: AW];

    // Read port: stored value, optionally overridden by a same-cycle write.
    always_comb begin
      data = regs_q[idx];
      bsy  = busy_q[idx];
`ifdef REGFILE_BYPASS_EN
      if (w1_act && (wr1 == idx)) begin
        data = wd1;
        bsy  = iss_act && (iss_rd == idx);
      end else if (w0_act && (wr0 == idx)) begin
        data = wd0;
        bsy  = iss_act && (iss_rd == idx);
      end
`endif
      if (idx == '0) begin
        data = '0;
        bsy  = 1'b0;
      end
    end

    assign rd_flat[g*XLEN +: XLEN] = data;
    assign rbusy[g]                = bsy;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed steps then randomized traffic, checked
// against an array-based model of the architectural registers and scoreboard.
module tb_reg_file_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = $clog2(NREG);

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   rs_flat;
  logic [NRD*XLEN-1:0] rd_flat;
  logic [NRD-1:0]      rbusy;
  logic                we0, we1, iss_valid;
  logic [AW-1:0]       wr0, wr1, iss_rd;
  logic [XLEN-1:0]     wd0, wd1;
  logic                iss_waw;
  logic [AW:0]         busy_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural contents and busy flags.
  logic [XLEN-1:0] m_mem  [NREG];
  bit              m_busy [NREG];
  logic [XLEN-1:0] exp_q [$];

  reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .rs_flat(rs_flat), .rd_flat(rd_flat), .rbusy(rbusy),
    .we0(we0), .wr0(wr0), .wd0(wd0), .we1(we1), .wr1(wr1), .wd1(wd1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_waw(iss_waw), .busy_cnt(busy_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  task automatic m_clear();
    for (int r = 0; r < NREG; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int r = 1; r < NREG; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  function automatic logic [XLEN-1:0] m_read(input int idx);
    logic [XLEN-1:0] v;
    if (idx == 0) return '0;
    v = m_mem[idx];
`ifdef REGFILE_BYPASS_EN
    if (we1 && int'(wr1) == idx) v = wd1;
    else if (we0 && int'(wr0) == idx) v = wd0;
`endif
    return v;
  endfunction

  function automatic logic m_rbusy(input int idx);
    if (idx == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((we1 && int'(wr1) == idx) || (we0 && int'(wr0) == idx))
      return iss_valid && int'(iss_rd) == idx;
`endif
    return m_busy[idx];
  endfunction

  // One clock edge of architectural behaviour.
  task automatic m_edge();
    if (we0 && wr0 != 0) begin m_mem[wr0] = wd0; m_busy[wr0] = 1'b0; end
    if (we1 && wr1 != 0) begin m_mem[wr1] = wd1; m_busy[wr1] = 1'b0; end
    if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int rs_of(input int p);
    return int'(rs_flat[p*AW +: AW]);
  endfunction

  task automatic check_comb();
    logic exp_waw;
    for (int p = 0; p < NRD; p++) exp_q.push_back(m_read(rs_of(p)));
    for (int p = 0; p < NRD; p++) begin
      check("rd", rd_flat[p*XLEN +: XLEN], exp_q.pop_front());
      check("rbusy", XLEN'(rbusy[p]), XLEN'(m_rbusy(rs_of(p))));
    end
    exp_waw = iss_valid && iss_rd != 0 && m_busy[iss_rd];
    check("iss_waw", XLEN'(iss_waw), XLEN'(exp_waw));
    check("busy_cnt", XLEN'(busy_cnt), XLEN'(m_count()));
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    rs_flat = '0; we0 = 0; wr0 = '0; wd0 = '0;
    we1 = 0; wr1 = '0; wd1 = '0; iss_valid = 0; iss_rd = '0;
  endtask

  task automatic set_rs(input int p, input int idx);
    rs_flat[p*AW +: AW] = AW'(idx);
  endtask

  // Check outputs, advance one edge, update model, return to negedge.
  task automatic tick();
    #1 check_comb();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  initial begin
    // Reset
    idle();
    rst = 1'b1;
    m_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset check: every index on every port reads zero and not busy.
    for (int idx = 0; idx < NREG; idx++) begin
      for (int p = 0; p < NRD; p++) set_rs(p, idx);
      #1;
      for (int p = 0; p < NRD; p++) begin
        check("rst_rd", rd_flat[p*XLEN +: XLEN], '0);
        check("rst_rbusy", XLEN'(rbusy[p]), '0);
      end
      check("rst_cnt", XLEN'(busy_cnt), '0);
      @(negedge clk);
    end

    // Async reset mid-write: x10 written and x11 issued first.
    idle(); we0 = 1; wr0 = 10; wd0 = 32'h1234; iss_valid = 1; iss_rd = 11;
    tick();
    idle(); set_rs(0, 10); set_rs(1, 11);
    #1 check("pre_rst_x10", rd_flat[0 +: XLEN], 32'h1234);
    check("pre_rst_cnt", XLEN'(busy_cnt), 32'd1);
    we0 = 1; wr0 = 10; wd0 = 32'h9999; iss_valid = 1; iss_rd = 12;
    #1 rst = 1'b1;
    #1 check("async_rst_cnt", XLEN'(busy_cnt), '0);
    @(posedge clk);
    #2 idle(); rst = 1'b0; m_clear();
    @(negedge clk);
    set_rs(0, 10); set_rs(1, 12);
    #1 check("post_rst_x10", rd_flat[0 +: XLEN], '0);
    check("post_rst_busy12", XLEN'(rbusy[1]), '0);
    check("post_rst_cnt", XLEN'(busy_cnt), '0);
    tick();

    // x0 handling
    idle(); we0 = 1; wr0 = 0; wd0 = 32'hDEADBEEF; iss_valid = 1; iss_rd = 0;
    #1 check("x0_waw", XLEN'(iss_waw), '0);
    tick();
    idle();
    #1 check("x0_rd", rd_flat[0 +: XLEN], '0);
    check("x0_cnt", XLEN'(busy_cnt), '0);

    // Dual-write collision: port 1 wins.
    idle(); we0 = 1; wr0 = 5; wd0 = 32'h11; we1 = 1; wr1 = 5; wd1 = 32'h22;
    tick();
    idle(); set_rs(0, 5);
    #1 check("collide_x5", rd_flat[0 +: XLEN], 32'h22);

    // Scoreboard
    idle(); iss_valid = 1; iss_rd = 3; tick();
    idle(); iss_valid = 1; iss_rd = 7; tick();
    idle(); set_rs(0, 3); set_rs(1, 7);
    #1 check("sb_cnt2", XLEN'(busy_cnt), 32'd2);
    check("sb_rbusy3", XLEN'(rbusy[0]), 32'd1);
    iss_valid = 1; iss_rd = 3;
    #1 check("sb_waw3", XLEN'(iss_waw), 32'd1);
    tick();
    idle(); set_rs(0, 3); we0 = 1; wr0 = 3; wd0 = 32'h33; tick();
    idle(); set_rs(0, 3);
    #1 check("sb_cnt1", XLEN'(busy_cnt), 32'd1);
    check("sb_rbusy3_clr", XLEN'(rbusy[0]), '0);
    check("sb_x3", rd_flat[0 +: XLEN], 32'h33);

    // Issue/write race on x9: data lands, busy stays set.
    idle(); iss_valid = 1; iss_rd = 9; we0 = 1; wr0 = 9; wd0 = 32'h55; tick();
    idle(); set_rs(0, 9);
    #1 check("race_x9", rd_flat[0 +: XLEN], 32'h55);
    check("race_busy9", XLEN'(rbusy[0]), 32'd1);
    check("race_cnt", XLEN'(busy_cnt), 32'd2);

    // Bypass (or its absence) on x4.
    idle(); set_rs(0, 4); we1 = 1; wr1 = 4; wd1 = 32'hCAFE;
`ifdef REGFILE_BYPASS_EN
    #1 check("byp_same", rd_flat[0 +: XLEN], 32'hCAFE);
`else
    #1 check("byp_same", rd_flat[0 +: XLEN], '0);
`endif
    tick();
    idle(); set_rs(0, 4);
    #1 check("byp_next", rd_flat[0 +: XLEN], 32'hCAFE);
    tick();

    // Randomized traffic, indices biased toward a small window for collisions.
    for (int n = 0; n < 400; n++) begin
      int lim;
      lim = ($urandom_range(0, 3) == 0) ? NREG - 1 : 7;
      for (int p = 0; p < NRD; p++) set_rs(p, $urandom_range(0, lim));
      we0 = 1'($urandom_range(0, 1)); wr0 = AW'($urandom_range(0, lim)); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wr1 = AW'($urandom_range(0, lim)); wd1 = $urandom;
      iss_valid = 1'($urandom_range(0, 1)); iss_rd = AW'($urandom_range(0, lim));
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file for the pipelined RISC-V core; successor to the single-write, two-read register file.
- Provides NRD read ports and two write ports: port 0 for ALU writeback, port 1 for load/late writeback.
- Adds a per-register scoreboard. A busy bit is set when an instruction issues with a destination and cleared on writeback. The decode stage uses it for RAW/WAW interlock.
- Sits between decode/issue and the writeback stages.

Parameters:
- XLEN, 32, register data width in bits.
- NREG, 32, number of architectural registers, power of two, at least 2; register 0 hardwired to zero.
- NRD, 2, number of read ports, 1..4.
- AW, $clog2(NREG), register index width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- rs_flat  input  NRD*AW  read indices; port i occupies bits [i*AW +: AW].
- rd_flat  output  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]; combinational.
- rbusy  output  NRD  busy bit of each read port's register; combinational.
- we0  input  1  write enable, port 0.
- wr0  input  AW  write index, port 0.
- wd0  input  XLEN  write data, port 0.
- we1  input  1  write enable, port 1.
- wr1  input  AW  write index, port 1.
- wd1  input  XLEN  write data, port 1.
- iss_valid  input  1  an instruction with a destination register issues this cycle.
- iss_rd  input  AW  destination index of the issuing instruction.
- iss_waw  output  1  combinational; high when iss_rd != 0 and busy[iss_rd] = 1.
- busy_cnt  output  AW+1  number of registers currently busy; registered.

Behaviour:
- Reset (rst high, asynchronous):
  - all registers 1..NREG-1 cleared to 0;
  - all busy bits cleared;
  - busy_cnt = 0.
  - Reset asserted mid-operation discards pending issues and writes in that cycle.
- Register 0:
  - reads return 0 and rbusy = 0;
  - writes and issues to index 0 are ignored;
  - iss_waw is never asserted for index 0;
  - busy_cnt never counts register 0.
- Reads:
  - combinational from current array state, zero cycles of latency;
  - all NRD ports are independent and may address the same register.
- Writes:
  - wd0 is stored into wr0 on the rising edge when we0 = 1 (same for port 1).
  - If both ports write the same nonzero index in one cycle, port 1 data wins.
  - A write clears busy for its index.
- Issue: when iss_valid = 1 and iss_rd != 0, busy[iss_rd] is set on the edge.
- Same-cycle issue and write to the same index: issue wins, so busy stays 1 (a new producer supersedes the old one). The data write still occurs.
- An issue to a register that is already busy is legal; the bit stays 1. iss_waw only informs decode, which decides whether to stall.
- busy_cnt update:
  - recomputed each edge as next = current + (bits newly set) − (bits newly cleared);
  - it always equals the popcount of the busy bits after the edge;
  - it never wraps: its maximum is NREG-1 and it is never negative.
- Writes to a non-busy register are legal; busy stays 0 and busy_cnt is unchanged.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port whose index matches an active same-cycle write (we0/we1, nonzero index) returns that write data instead of the stored value. Port 1 has priority over port 0.
  - rbusy for that port reads 0 unless a same-cycle issue targets the same index.
- Undefined:
  - Reads return the stored array value only; new data is visible the cycle after the write.
  - rbusy reflects the registered busy bits only.

Test Plan:
- Reset check: reset, then read all indices on every port -> every rd = 0, rbusy = 0, busy_cnt = 0. Assert rst asynchronously mid-write -> the write is lost and all state is 0.
- x0 handling: we0 = 1, wr0 = 0, wd0 = 0xDEADBEEF, plus an issue to x0 -> read x0 = 0, busy_cnt stays 0, iss_waw = 0.
- Dual-write collision: we0 = we1 = 1, wr = 5, wd0 = 0x11, wd1 = 0x22 -> next cycle x5 = 0x22.
- Scoreboard:
  - issue x3, then x7 -> busy_cnt = 2 and rbusy is set for reads of x3;
  - re-issue x3 -> iss_waw = 1;
  - write x3 -> busy_cnt = 1.
- Issue/write race: issue x9 and we0 to x9 with 0x55 in the same cycle -> x9 = 0x55, busy[9] = 1, busy_cnt increments by 1.
- Bypass:
  - we1 to x4 with 0xCAFE while rs0 = 4 -> with REGFILE_BYPASS_EN, rd0 = 0xCAFE the same cycle;
  - without it, rd0 shows the old value, then 0xCAFE the next cycle.
